bb_link_mode_ctrl: RTL and testbench

- Mode controller for the Bus Blaster CPLD. Decides whether the shared target-side pins run as the JTAG buffer or as the Playstation 2 UART receive path (RX on nTRST).
- Takes mode requests from the board BUTTON and from a host-driven FT GPIOH level.
- Switches only after the outgoing link is idle, then inserts a break-before-make gap before enabling the new path.
- Its outputs drive the output-enable and mux selects in the top-level buffer.

---
 rtl/bb_link_mode_ctrl_pkg.sv | 49 ++++
 rtl/bb_sync_debounce.sv | 37 +++
 rtl/bb_link_mode_ctrl.sv | 154 +++++++++++++++
 tb/tb_bb_link_mode_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/bb_link_mode_ctrl_pkg.sv
// Shared definitions for the Bus Blaster link mode controller.
// Covers the state encodings, the mode constants and the per-state output table.
package bb_link_mode_ctrl_pkg;

    typedef enum logic [2:0] {
        S_JTAG     = 3'd0,
        S_DRAIN_J  = 3'd1,
        S_GAP_TO_U = 3'd2,
        S_UART     = 3'd3,
        S_DRAIN_U  = 3'd4,
        S_GAP_TO_J = 3'd5
    } state_t;

    localparam logic MODE_JTAG = 1'b0;
    localparam logic MODE_UART = 1'b1;

    typedef struct packed {
        logic sel_uart;
        logic jtag_oe;
        logic uart_en;
        logic busy;
    } link_out_t;

    function automatic link_out_t state_outputs(input state_t s);
        case (s)
            S_JTAG:     return '{sel_uart: 1'b0, jtag_oe: 1'b1, uart_en: 1'b0, busy: 1'b0};
            S_DRAIN_J:  return '{sel_uart: 1'b0, jtag_oe: 1'b1, uart_en: 1'b0, busy: 1'b1};
            S_GAP_TO_U: return '{sel_uart: 1'b0, jtag_oe: 1'b0, uart_en: 1'b0, busy: 1'b1};
            S_UART:     return '{sel_uart: 1'b1, jtag_oe: 1'b0, uart_en: 1'b1, busy: 1'b0};
            S_DRAIN_U:  return '{sel_uart: 1'b1, jtag_oe: 1'b0, uart_en: 1'b1, busy: 1'b1};
            S_GAP_TO_J: return '{sel_uart: 1'b0, jtag_oe: 1'b0, uart_en: 1'b0, busy: 1'b1};
            default:    return '{sel_uart: 1'b0, jtag_oe: 1'b1, uart_en: 1'b0, busy: 1'b0};
        endcase
    endfunction

    // Mode the controller is in or heading to; a press asks for the other one.
    function automatic logic pending_mode(input state_t s);
        return (s == S_JTAG || s == S_DRAIN_U || s == S_GAP_TO_J) ? MODE_JTAG : MODE_UART;
    endfunction

    function automatic logic is_drain(input state_t s);
        return (s == S_DRAIN_J || s == S_DRAIN_U);
    endfunction

    function automatic logic is_gap(input state_t s);
        return (s == S_GAP_TO_U || s == S_GAP_TO_J);
    endfunction

endpackage

// File: rtl/bb_sync_debounce.sv
// Two-flop synchroniser followed by a stable-count debounce filter.
// The level follows the input only after DEBOUNCE_CYCLES consecutive differing samples.
module bb_sync_debounce #(
    parameter int   DEBOUNCE_CYCLES = 8192,
    parameter logic RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= {2{RESET_LEVEL}};
            level <= RESET_LEVEL;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bb_link_mode_ctrl.sv
// Selects JTAG buffer or PS2 UART receive on the shared target pins.
// Drains the outgoing link, then inserts a break-before-make gap before enabling the new path.
module bb_link_mode_ctrl
    import bb_link_mode_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8192,
    parameter int IDLE_CYCLES     = 1024,
    parameter int GAP_CYCLES      = 16,
    parameter int DRAIN_TIMEOUT   = 65536,
    parameter int BLINK_W         = 22
) (
    input  logic CLK,
    input  logic RST,
    input  logic BUTTON,
    input  logic HOST_MODE,
    input  logic FT_TCK,
    input  logic FT_TMS,
    input  logic UART_RX,
    output logic SEL_UART,
    output logic JTAG_OE,
    output logic UART_EN,
    output logic BUSY,
    output logic LED
);

    localparam int             IW         = $clog2(IDLE_CYCLES + 1);
    localparam int             DW         = $clog2(DRAIN_TIMEOUT + 1);
    localparam int             GW         = $clog2(GAP_CYCLES + 1);
    localparam logic [IW-1:0]  IDLE_LAST  = IW'(IDLE_CYCLES - 1);
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
    localparam logic [GW-1:0]  GAP_LAST   = GW'(GAP_CYCLES - 1);

    state_t            state, state_nxt;
    logic [1:0]        host_s, tck_s, tms_s, rx_s;
    logic              host_hist, tck_prev, tms_prev, btn_prev, btn_level;
    logic [IW-1:0]     idle_cnt;
    logic [DW-1:0]     drain_cnt;
    logic [GW-1:0]     gap_cnt;
    logic [BLINK_W-1:0] blink;
    logic              press, host_req, req, req_mode, activity, drain_done, gap_done;
    link_out_t         out_nxt;
    logic              led_nxt;

    bb_sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (1'b1)
    ) u_button (
        .clk   (CLK),
        .rst   (RST),
        .raw   (BUTTON),
        .level (btn_level)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            host_s    <= 2'b00;
            tck_s     <= 2'b00;
            tms_s     <= 2'b00;
            rx_s      <= 2'b11;
            host_hist <= 1'b0;
            tck_prev  <= 1'b0;
            tms_prev  <= 1'b0;
            btn_prev  <= 1'b1;
            blink     <= '0;
        end else begin
            host_s    <= {host_s[0], HOST_MODE};
            tck_s     <= {tck_s[0], FT_TCK};
            tms_s     <= {tms_s[0], FT_TMS};
            rx_s      <= {rx_s[0], UART_RX};
            host_hist <= host_s[1];
            tck_prev  <= tck_s[1];
            tms_prev  <= tms_s[1];
            btn_prev  <= btn_level;
            blink     <= blink + 1'b1;
        end
    end

    // Host edge takes priority over a simultaneous press.
    assign press    = btn_prev & ~btn_level;
    assign host_req = host_s[1] ^ host_hist;
    assign req      = host_req | press;
    assign req_mode = host_req ? host_s[1] : ~pending_mode(state);

    assign activity   = (state == S_DRAIN_J) ? ((tck_s[1] ^ tck_prev) | (tms_s[1] ^ tms_prev))
                                             : ~rx_s[1];
    assign drain_done = (idle_cnt == IDLE_LAST) || (drain_cnt == DRAIN_LAST);
    assign gap_done   = (gap_cnt == GAP_LAST);

    // Counters sit at zero outside their phase, so entry always starts from zero.
    always_ff @(posedge CLK) begin
        if (RST || !is_drain(state)) begin
            idle_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + 1'b1;
            if (activity)
                idle_cnt <= '0;
            else if (idle_cnt != IDLE_LAST)
                idle_cnt <= idle_cnt + 1'b1;
        end
        if (RST || !is_gap(state))
            gap_cnt <= '0;
        else
            gap_cnt <= gap_cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_JTAG;
            SEL_UART <= 1'b0;
            JTAG_OE  <= 1'b1;
            UART_EN  <= 1'b0;
            BUSY     <= 1'b0;
            LED      <= 1'b1;
        end else begin
            state    <= state_nxt;
            SEL_UART <= out_nxt.sel_uart;
            JTAG_OE  <= out_nxt.jtag_oe;
            UART_EN  <= out_nxt.uart_en;
            BUSY     <= out_nxt.busy;
            LED      <= led_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_JTAG:     if (req && req_mode == MODE_UART) state_nxt = S_DRAIN_J;
            S_UART:     if (req && req_mode == MODE_JTAG) state_nxt = S_DRAIN_U;
            S_DRAIN_J: begin
                if (req && req_mode == MODE_JTAG) state_nxt = S_JTAG;
                else if (drain_done)              state_nxt = S_GAP_TO_U;
            end
            S_DRAIN_U: begin
                if (req && req_mode == MODE_UART) state_nxt = S_UART;
                else if (drain_done)              state_nxt = S_GAP_TO_J;
            end
            S_GAP_TO_U: if (gap_done) state_nxt = S_UART;
            S_GAP_TO_J: if (gap_done) state_nxt = S_JTAG;
            default:    state_nxt = S_JTAG;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        out_nxt = state_outputs(state_nxt);
        led_nxt = blink[BLINK_W-3];
        if (state_nxt == S_JTAG)
            led_nxt = 1'b1;
        else if (state_nxt == S_UART)
            led_nxt = blink[BLINK_W-1];
    end

endmodule

// File: tb/tb_bb_link_mode_ctrl.sv
// Directed bench for bb_link_mode_ctrl with short debounce/idle/gap/timeout settings.
// Observed vector is {SEL_UART, JTAG_OE, UART_EN, BUSY, LED}.
module tb_bb_link_mode_ctrl;

    localparam logic [4:0] O_JTAG  = 5'b01001;
    localparam logic [4:0] O_DRNJ  = 5'b01010;
    localparam logic [4:0] O_GAP   = 5'b00010;
    localparam logic [4:0] O_UART  = 5'b10100;
    localparam logic [4:0] O_DRNU  = 5'b10110;

    logic CLK = 1'b0;
    logic RST, BUTTON, HOST_MODE, FT_TCK, FT_TMS, UART_RX;
    logic SEL_UART, JTAG_OE, UART_EN, BUSY, LED;
    logic [4:0] outs;
    int tests  = 0;
    int failed = 0;

    assign outs = {SEL_UART, JTAG_OE, UART_EN, BUSY, LED};

    always #5 CLK = ~CLK;

    bb_link_mode_ctrl #(
        .DEBOUNCE_CYCLES (8),
        .IDLE_CYCLES     (16),
        .GAP_CYCLES      (4),
        .DRAIN_TIMEOUT   (64),
        .BLINK_W         (22)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .BUTTON    (BUTTON),
        .HOST_MODE (HOST_MODE),
        .FT_TCK    (FT_TCK),
        .FT_TMS    (FT_TMS),
        .UART_RX   (UART_RX),
        .SEL_UART  (SEL_UART),
        .JTAG_OE   (JTAG_OE),
        .UART_EN   (UART_EN),
        .BUSY      (BUSY),
        .LED       (LED)
    );

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [4:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            chk(tag, outs, exp);
        end
    endtask

    initial begin
        RST = 1'b1; BUTTON = 1'b1; HOST_MODE = 1'b0;
        FT_TCK = 1'b0; FT_TMS = 1'b0; UART_RX = 1'b1;

        // 1: reset and idle
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_state", outs, O_JTAG);
        RST = 1'b0;
        run("s1_idle", O_JTAG, 100);

        // 2: host asks for UART on a quiet JTAG link
        HOST_MODE = 1'b1;
        run("s2_sync", O_JTAG, 2);
        run("s2_drain", O_DRNJ, 16);
        run("s2_gap", O_GAP, 4);
        run("s2_uart", O_UART, 5);

        // 3a: 3-cycle bounce is filtered
        BUTTON = 1'b0;
        run("s3_bounce_lo", O_UART, 3);
        BUTTON = 1'b1;
        run("s3_bounce_hi", O_UART, 12);

        // 3b: held press switches to JTAG after 16 quiet RX cycles
        BUTTON = 1'b0;
        run("s3_debounce", O_UART, 10);
        run("s3_drain_a", O_DRNU, 10);
        BUTTON = 1'b1;
        run("s3_drain_b", O_DRNU, 6);
        run("s3_gap", O_GAP, 4);
        run("s3_jtag", O_JTAG, 5);

        // host edge back to JTAG while already in JTAG is ignored
        HOST_MODE = 1'b0;
        run("s4_ignored", O_JTAG, 6);

        // 4: TCK toggling every 5 cycles forces the 64-cycle timeout
        HOST_MODE = 1'b1;
        run("s4_sync", O_JTAG, 2);
        for (int i = 0; i < 64; i++) begin
            if (i % 5 == 0) FT_TCK = ~FT_TCK;
            @(posedge CLK);
            #1;
            chk("s4_drain", outs, O_DRNJ);
        end
        run("s4_gap", O_GAP, 4);
        run("s4_uart", O_UART, 3);

        // 3c: UART_RX pulsed low every 10 cycles holds drain until the timeout
        BUTTON = 1'b0;
        run("s3c_debounce", O_UART, 10);
        for (int i = 0; i < 64; i++) begin
            UART_RX = (i % 10 == 0) ? 1'b0 : 1'b1;
            if (i == 10) BUTTON = 1'b1;
            @(posedge CLK);
            #1;
            chk("s3c_drain", outs, O_DRNU);
        end
        UART_RX = 1'b1;
        run("s3c_gap", O_GAP, 4);
        run("s3c_jtag", O_JTAG, 8);

        // 5a: press and host edge land together; host (JTAG) wins, press dropped
        BUTTON = 1'b0;
        run("s5_btn", O_JTAG, 8);
        HOST_MODE = 1'b0;
        run("s5_coincide", O_JTAG, 12);
        BUTTON = 1'b1;
        run("s5_release", O_JTAG, 12);

        // 5b: abort from drain back to JTAG
        HOST_MODE = 1'b1;
        run("s5_sync", O_JTAG, 2);
        run("s5_drain", O_DRNJ, 5);
        HOST_MODE = 1'b0;
        run("s5_abort_sync", O_DRNJ, 2);
        run("s5_aborted", O_JTAG, 5);

        // 6: reset in the middle of the gap
        HOST_MODE = 1'b1;
        run("s6_sync", O_JTAG, 2);
        run("s6_drain", O_DRNJ, 16);
        run("s6_gap", O_GAP, 2);
        RST = 1'b1;
        HOST_MODE = 1'b0;
        run("s6_reset", O_JTAG, 2);
        RST = 1'b0;
        run("s6_after", O_JTAG, 10);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
